// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants for the seven-segment display scan driver.
//   SEG_A..SEG_G : bit positions of each segment in a 7-bit pattern (1 = lit)
//   SEG_W        : width of a segment pattern
//   FONT_TABLE   : hex nibble -> segment pattern, indexed by the nibble value
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G - SEG_A + 1;

    // Packed so that FONT_TABLE[n] is the pattern for nibble n; the leftmost
    // literal is entry 15 (F).
    localparam logic [15:0][SEG_W-1:0] FONT_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_font.sv
// -----------------------------------------------------------------------------
// seg7_font
// Combinational hex-nibble to seven-segment pattern decoder.
// Ports:
//   nibble : in  [3:0]        value to display
//   seg    : out [SEG_W-1:0]  segment pattern, bit SEG_A = a .. bit SEG_G = g
// -----------------------------------------------------------------------------
module seg7_font
    import disp_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = FONT_TABLE[nibble];

endmodule

// File: rtl/disp_scan_drv.sv
// -----------------------------------------------------------------------------
// disp_scan_drv
// Multiplexed seven-segment display scanner. Cycles a one-hot digit enable
// across NDIG digits, CLK_DIV clocks per digit, with DEAD blanking clocks at the
// start of every slot. Digit content comes from shadow registers captured on
// load. Optional leading-zero suppression, per-digit blanking and, when built
// with DISP_BLINK_EN, per-digit blinking.
//
// Parameters:
//   NDIG      : number of digits (1..8)
//   CLK_DIV   : clocks per digit slot (>= 2)
//   DEAD      : blanking clocks at slot start (0..CLK_DIV-1)
//   BLINK_DIV : full frames per blink half-period (only with DISP_BLINK_EN)
// Ports:
//   clk      : in   clock, rising edge
//   rst      : in   asynchronous active-high reset
//   data_in  : in   [4*NDIG-1:0] hex nibbles, digit i = data_in[4i+3:4i]
//   dp_in    : in   [NDIG-1:0] decimal point per digit
//   blank_in : in   [NDIG-1:0] force digit dark
//   lz_en    : in   leading-zero suppression enable (live, not shadowed)
//   load     : in   capture strobe for data_in / dp_in / blank_in
//   blink_in : in   [NDIG-1:0] blink select per digit (only with DISP_BLINK_EN)
//   seg      : out  [6:0] segments, bit0 = a .. bit6 = g, 1 = lit
//   dp       : out  decimal point, 1 = lit
//   an       : out  [NDIG-1:0] one-hot digit enable, 1 = active
// -----------------------------------------------------------------------------
module disp_scan_drv
    import disp_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int CLK_DIV   = 50000,
    parameter int DEAD      = 0
`ifdef DISP_BLINK_EN
    ,
    parameter int BLINK_DIV = 64
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] data_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic [NDIG-1:0]   blank_in,
    input  logic              lz_en,
    input  logic              load,
`ifdef DISP_BLINK_EN
    input  logic [NDIG-1:0]   blink_in,
`endif
    output logic [SEG_W-1:0]  seg,
    output logic              dp,
    output logic [NDIG-1:0]   an
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    // -------------------------------------------------------------------------
    // Shadow registers
    // -------------------------------------------------------------------------
    logic [4*NDIG-1:0] data_q;
    logic [NDIG-1:0]   dp_q;
    logic [NDIG-1:0]   blank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (load) begin
            data_q  <= data_in;
            dp_q    <= dp_in;
            blank_q <= blank_in;
        end
    end

    // -------------------------------------------------------------------------
    // Slot prescaler and digit index
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          presc_wrap;
    logic          idx_wrap;

    assign presc_wrap = (presc == PW'(CLK_DIV - 1));
    assign idx_wrap   = (idx == IW'(NDIG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc_wrap) begin
            presc <= '0;
            idx   <= idx_wrap ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Blink phase (frame counter toggles the phase every BLINK_DIV frames)
    // -------------------------------------------------------------------------
    logic blink_dark;

`ifdef DISP_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [FW-1:0] frame_cnt;
    logic          blink_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (presc_wrap && idx_wrap) begin
            if (frame_cnt == FW'(BLINK_DIV - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign blink_dark = ~blink_on & blink_in[idx];
`else
    assign blink_dark = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Digit selection and decode
    // -------------------------------------------------------------------------
    logic [3:0]       nibble_sel;
    logic [SEG_W-1:0] font_seg;
    logic [NDIG:0]    zero_from;   // zero_from[i]: nibbles i..NDIG-1 are all zero
    logic [NDIG-1:0]  onehot;
    logic             active;
    logic             suppress;
    logic             dark;

    assign nibble_sel = data_q[4*idx +: 4];

    seg7_font u_font (
        .nibble (nibble_sel),
        .seg    (font_seg)
    );

    always_comb begin
        zero_from       = '0;
        zero_from[NDIG] = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zero_from[i] = (data_q[4*i +: 4] == 4'h0) && zero_from[i+1];
        end
    end

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

    // DEAD = 0 would make the compare a tautology, so it is not built at all.
    if (DEAD == 0) begin : g_no_dead
        assign active = 1'b1;
    end else begin : g_dead
        assign active = (presc >= PW'(DEAD));
    end

    // Digit 0 is exempt so an all-zero value still shows a single "0".
    assign suppress = lz_en && (idx != '0) && zero_from[idx];
    assign dark     = ~active | blank_q[idx] | blink_dark;

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= '0;
            dp  <= 1'b0;
            an  <= '0;
        end else begin
            an  <= active ? onehot : '0;
            seg <= (dark || suppress) ? '0 : font_seg;
            dp  <= dark ? 1'b0 : dp_q[idx];
        end
    end

endmodule

// File: tb/tb_disp_scan_drv.sv
module tb_disp_scan_drv;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_en;
    logic        load;
`ifdef DISP_BLINK_EN
    logic [3:0]  blink_in;
`endif
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    disp_scan_drv #(
        .NDIG      (4),
        .CLK_DIV   (4),
        .DEAD      (1)
`ifdef DISP_BLINK_EN
        ,
        .BLINK_DIV (2)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .blank_in (blank_in),
        .lz_en    (lz_en),
        .load     (load),
`ifdef DISP_BLINK_EN
        .blink_in (blink_in),
`endif
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    typedef struct {
        logic        lz;
        logic [15:0] data;
        logic [3:0]  dpv;
        logic [3:0]  blank;
        logic [27:0] seg_exp;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  dp_exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for the given digit to be enabled; sampled on negedges.
    task automatic wait_an(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an == 4'(1 << d)) begin
                ok = 1'b1;
                return;
            end
        end
        tests++;
        errors++;
        $display("FAIL wait_an digit %0d: an stuck at %b, expected %b", d, an, 4'(1 << d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [6:0] exp_s [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;

        vecs[0] = '{1'b1, 16'h0070, 4'b0000, 4'b0000, {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000};
        vecs[1] = '{1'b0, 16'h0070, 4'b0000, 4'b0000, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0000};
        vecs[2] = '{1'b1, 16'h0000, 4'b0100, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0100};
        vecs[3] = '{1'b0, 16'hFFFF, 4'b0001, 4'b0001, {7'h71, 7'h71, 7'h71, 7'h00}, 4'b0000};
        vecs[4] = '{1'b0, 16'hABCD, 4'b1010, 4'b0000, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b1010};
        vecs[5] = '{1'b1, 16'h0508, 4'b0000, 4'b0100, {7'h00, 7'h00, 7'h3F, 7'h7F}, 4'b0000};
        vecs[6] = '{1'b1, 16'h0009, 4'b1000, 4'b1000, {7'h00, 7'h00, 7'h00, 7'h6F}, 4'b0000};
        vecs[7] = '{1'b0, 16'h6E21, 4'b0000, 4'b0000, {7'h7D, 7'h79, 7'h5B, 7'h06}, 4'b0000};

        rst      = 1'b1;
        data_in  = '0;
        dp_in    = '0;
        blank_in = '0;
        lz_en    = 1'b0;
        load     = 1'b0;
`ifdef DISP_BLINK_EN
        blink_in = '0;
`endif
        repeat (2) @(negedge clk);
        check("reset seg", 32'(seg), 32'h0);
        check("reset dp",  32'(dp),  32'h0);
        check("reset an",  32'(an),  32'h0);

        // Full scan sequence right after reset, load on the first edge.
        exp_s = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        rst     = 1'b0;
        load    = 1'b1;
        data_in = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            exp_an  = ((k % 4) == 0) ? 4'b0000 : 4'(1 << (k / 4));
            exp_seg = ((k % 4) == 0) ? 7'h00 : exp_s[k / 4];
            check($sformatf("scan an k=%0d", k), 32'(an), 32'(exp_an));
            check($sformatf("scan seg k=%0d", k), 32'(seg), 32'(exp_seg));
        end

        // Table-driven digit content checks.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            data_in  = vecs[v].data;
            dp_in    = vecs[v].dpv;
            blank_in = vecs[v].blank;
            lz_en    = vecs[v].lz;
            load     = 1'b1;
            @(negedge clk);
            load = 1'b0;
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                wait_an(d, ok);
                if (ok) begin
                    check($sformatf("vec%0d d%0d seg", v, d), 32'(seg), 32'(vecs[v].seg_exp[7*d +: 7]));
                    check($sformatf("vec%0d d%0d dp", v, d), 32'(dp), 32'(vecs[v].dp_exp[d]));
                end
            end
        end

        // Asynchronous reset in the middle of digit 2's slot.
        wait_an(2, ok);
        if (ok) begin
            check("pre-rst d2 seg", 32'(seg), 32'h79);
            #2;
            rst = 1'b1;
            #1;
            check("mid rst seg", 32'(seg), 32'h0);
            check("mid rst dp",  32'(dp),  32'h0);
            check("mid rst an",  32'(an),  32'h0);
            @(negedge clk);
            rst   = 1'b0;
            lz_en = 1'b1;
            @(negedge clk);
            check("post rst dead an", 32'(an), 32'h0);
            @(negedge clk);
            check("post rst an",  32'(an),  32'b0001);
            check("post rst seg", 32'(seg), 32'h3F);
            check("post rst dp",  32'(dp),  32'h0);
        end

`ifdef DISP_BLINK_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        load     = 1'b1;
        data_in  = 16'h8000;
        dp_in    = '0;
        blank_in = '0;
        lz_en    = 1'b0;
        blink_in = 4'b1000;
        @(negedge clk);
        load = 1'b0;
        for (int f = 0; f < 8; f++) begin
            wait_an(3, ok);
            if (ok) check($sformatf("blink f%0d d3 seg", f), 32'(seg), (((f / 2) % 2) == 0) ? 32'h7F : 32'h00);
            wait_an(0, ok);
            if (ok) check($sformatf("blink f%0d d0 seg", f), 32'(seg), 32'h3F);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
